store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 28 ++
 rtl/store_align.sv | 27 ++
 rtl/store_unit.sv | 149 ++++++++++++++
 tb/tb_store_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared load/store unit types, funct3 codes and size mask helper
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } store_state_t;

    // Byte mask of an access, right-justified; unsigned loads share the signed sizes.
    function automatic logic [3:0] size_to_mask(input logic [2:0] funct3);
        logic [3:0] mask;
        case (funct3)
            F3_B, F3_BU: mask = 4'b0001;
            F3_H, F3_HU: mask = 4'b0011;
            F3_W:        mask = 4'b1111;
            default:     mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/store_align.sv
// rtl/store_align.sv - combinational store lane alignment and byte-enable generation
module store_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    output logic [63:0] shifted,
    output logic [7:0]  be8,
    output logic        illegal,
    output logic        crossing
);

    logic [3:0]  mask;
    logic [31:0] data_masked;

    // Unused lanes are zeroed before shifting so disabled byte lanes never carry data.
    always_comb begin
        illegal     = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W));
        mask        = illegal ? 4'b0000 : size_to_mask(funct3);
        data_masked = store_data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        shifted     = {32'b0, data_masked} << {off, 3'b000};
        be8         = {4'b0000, mask} << off;
        crossing    = |be8[7:4];
    end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - RV32 store unit issuing word-aligned, possibly split, memory writes
module store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W           = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [31:0]       instruction_data,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [31:0]       store_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_gnt,
    output logic              done_o,
    output logic              err_o
);

    store_state_t      state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       b1_wdata_q, b1_wdata_d;
    logic [3:0]        b1_be_q, b1_be_d;
    logic              cross_q, cross_d;

    logic [63:0] shifted;
    logic [7:0]  be8;
    logic        illegal;
    logic        crossing;
    logic        unused_instr_bits;

    assign unused_instr_bits = ^{instruction_data[31:15], instruction_data[11:0]};

    store_align u_align (
        .funct3     (instruction_data[14:12]),
        .off        (data_address[1:0]),
        .store_data (store_data),
        .shifted    (shifted),
        .be8        (be8),
        .illegal    (illegal),
        .crossing   (crossing)
    );

    // Next-state logic: accept in IDLE, then walk one or two beats, each held until granted.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        b1_wdata_d  = b1_wdata_q;
        b1_be_d     = b1_be_q;
        cross_d     = cross_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (illegal || (crossing && !SPLIT_MISALIGNED)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = BEAT0;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {data_address[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = shifted[31:0];
                        mem_be_d    = be8[3:0];
                        b1_wdata_d  = shifted[63:32];
                        b1_be_d     = be8[7:4];
                        cross_d     = crossing;
                    end
                end
            end
            BEAT0: begin
                if (mem_gnt) begin
                    if (cross_q) begin
                        state_d     = BEAT1;
                        mem_addr_d  = mem_addr_q + ADDR_W'(4);
                        mem_wdata_d = b1_wdata_q;
                        mem_be_d    = b1_be_q;
                    end else begin
                        state_d     = IDLE;
                        mem_req_d   = 1'b0;
                        mem_wdata_d = 32'b0;
                        mem_be_d    = 4'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (mem_gnt) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    mem_wdata_d = 32'b0;
                    mem_be_d    = 4'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'b0;
            mem_be_q    <= 4'b0;
            b1_wdata_q  <= 32'b0;
            b1_be_q     <= 4'b0;
            cross_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            b1_wdata_q  <= b1_wdata_d;
            b1_be_q     <= b1_be_d;
            cross_q     <= cross_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ready_o   = (state_q == IDLE);
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - self-checking bench for store_unit
module tb_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        valid0_i = 1'b0;
    logic [31:0] instruction_data = 32'b0;
    logic [31:0] data_address = 32'b0;
    logic [31:0] store_data = 32'b0;
    logic        mem_gnt = 1'b0;
    logic        gnt0 = 1'b1;

    logic        ready_o, mem_req, done_o, err_o;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        ready0, req0, done0, err0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  be0;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } beat_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        int          dly;
        logic        exp_err;
        int          nbeats;
        logic [31:0] a0;
        logic [31:0] w0;
        logic [3:0]  b0;
        logic [31:0] a1;
        logic [31:0] w1;
        logic [3:0]  b1;
    } vec_t;

    beat_t exp_q[$];
    vec_t  vecs[10];

    always #5 clk = ~clk;

    store_unit #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .instruction_data(instruction_data), .data_address(data_address),
        .store_data(store_data), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .done_o(done_o), .err_o(err_o)
    );

    store_unit #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) u_dut_nosplit (
        .clk(clk), .rst_n(rst_n), .valid_i(valid0_i), .ready_o(ready0),
        .instruction_data(instruction_data), .data_address(data_address),
        .store_data(store_data), .mem_req(req0), .mem_addr(addr0),
        .mem_wdata(wdata0), .mem_be(be0), .mem_gnt(gnt0),
        .done_o(done0), .err_o(err0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [2:0] f3);
        return {17'b0, f3, 5'b0, 7'b0100011};
    endfunction

    // Called at a negedge; returns at the negedge where done_o or err_o was checked.
    task automatic run_vec(input vec_t v);
        int    cyc;
        int    wait_cnt;
        int    guard;
        bit    done_seen;
        beat_t b;
        guard = 0;
        while (!ready_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
        instruction_data = mk_instr(v.f3);
        data_address     = v.addr;
        store_data       = v.data;
        valid_i          = 1'b1;
        if (!v.exp_err) begin
            b.addr = v.a0; b.wdata = v.w0; b.be = v.b0;
            exp_q.push_back(b);
            if (v.nbeats == 2) begin
                b.addr = v.a1; b.wdata = v.w1; b.be = v.b1;
                exp_q.push_back(b);
            end
        end
        @(posedge clk);
        #1 valid_i = 1'b0;
        if (v.exp_err) begin
            @(negedge clk);
            check("err_pulse", {63'b0, err_o}, 64'd1);
            check("err_no_req", {63'b0, mem_req}, 64'd0);
            check("err_ready", {63'b0, ready_o}, 64'd1);
            @(negedge clk);
            check("err_one_cycle", {63'b0, err_o}, 64'd0);
            check("err_still_no_req", {63'b0, mem_req}, 64'd0);
            return;
        end
        cyc = 0;
        wait_cnt = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            mem_gnt = 1'b0;
            if (done_o) begin
                done_seen = 1'b1;
                check("done_cycle", 64'(cyc), 64'(1 + v.nbeats * (v.dly + 1)));
                check("done_req_low", {63'b0, mem_req}, 64'd0);
                check("done_be_zero", {60'b0, mem_be}, 64'd0);
                check("done_ready", {63'b0, ready_o}, 64'd1);
                check("beats_left", 64'(exp_q.size()), 64'd0);
            end else if (mem_req) begin
                check("busy_not_ready", {63'b0, ready_o}, 64'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_beat: got addr %h expected no request", mem_addr);
                end else begin
                    check("beat_addr", {32'b0, mem_addr}, {32'b0, exp_q[0].addr});
                    check("beat_wdata", {32'b0, mem_wdata}, {32'b0, exp_q[0].wdata});
                    check("beat_be", {60'b0, mem_be}, {60'b0, exp_q[0].be});
                    if (wait_cnt >= v.dly) begin
                        mem_gnt = 1'b1;
                        void'(exp_q.pop_front());
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
        mem_gnt = 1'b0;
        if (!done_seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done_o expected done within 40 cycles");
        end
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{3'b000, 32'h0000_1003, 32'hAABB_CCDD, 0, 1'b0, 1, 32'h0000_1000, 32'hDD00_0000, 4'b1000, 32'h0, 32'h0, 4'h0};
        vecs[1] = '{3'b001, 32'h0000_2002, 32'h0000_1234, 3, 1'b0, 1, 32'h0000_2000, 32'h1234_0000, 4'b1100, 32'h0, 32'h0, 4'h0};
        vecs[2] = '{3'b010, 32'h0000_3001, 32'h1122_3344, 0, 1'b0, 2, 32'h0000_3000, 32'h2233_4400, 4'b1110, 32'h0000_3004, 32'h0000_0011, 4'b0001};
        vecs[3] = '{3'b010, 32'hFFFF_FFFE, 32'hCAFE_BABE, 0, 1'b0, 2, 32'hFFFF_FFFC, 32'hBABE_0000, 4'b1100, 32'h0000_0000, 32'h0000_CAFE, 4'b0011};
        vecs[4] = '{3'b011, 32'h0000_1000, 32'h1234_5678, 0, 1'b1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
        vecs[5] = '{3'b010, 32'h0000_5000, 32'hDEAD_BEEF, 0, 1'b0, 1, 32'h0000_5000, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'h0, 4'h0};
        vecs[6] = '{3'b001, 32'h0000_6003, 32'hFFFF_5678, 0, 1'b0, 2, 32'h0000_6000, 32'h7800_0000, 4'b1000, 32'h0000_6004, 32'h0000_0056, 4'b0001};
        vecs[7] = '{3'b000, 32'h0000_7000, 32'h1234_5678, 1, 1'b0, 1, 32'h0000_7000, 32'h0000_0078, 4'b0001, 32'h0, 32'h0, 4'h0};
        vecs[8] = '{3'b100, 32'h0000_7000, 32'h1234_5678, 0, 1'b1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
        vecs[9] = '{3'b001, 32'h0000_8001, 32'h0000_ABCD, 0, 1'b0, 1, 32'h0000_8000, 32'h00AB_CD00, 4'b0110, 32'h0, 32'h0, 4'h0};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req", {63'b0, mem_req}, 64'd0);
        check("rst_addr", {32'b0, mem_addr}, 64'd0);
        check("rst_wdata", {32'b0, mem_wdata}, 64'd0);
        check("rst_be", {60'b0, mem_be}, 64'd0);
        check("rst_done", {63'b0, done_o}, 64'd0);
        check("rst_err", {63'b0, err_o}, 64'd0);
        check("rst_ready", {63'b0, ready_o}, 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors; each starts in the completing cycle of the previous one
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Reset while waiting in BEAT1
        @(negedge clk);
        instruction_data = mk_instr(3'b010);
        data_address     = 32'h0000_3001;
        store_data       = 32'h1122_3344;
        valid_i          = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        @(negedge clk);
        check("rstmid_beat0_req", {63'b0, mem_req}, 64'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("rstmid_beat1_addr", {32'b0, mem_addr}, 64'h0000_3004);
        check("rstmid_beat1_be", {60'b0, mem_be}, 64'b0001);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_req_low", {63'b0, mem_req}, 64'd0);
        check("rstmid_idle", {63'b0, ready_o}, 64'd1);
        check("rstmid_be", {60'b0, mem_be}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_no_done", {63'b0, done_o}, 64'd0);
        check("rstmid_still_no_req", {63'b0, mem_req}, 64'd0);
        v = '{3'b010, 32'h0000_4000, 32'h0BAD_F00D, 0, 1'b0, 1, 32'h0000_4000, 32'h0BAD_F00D, 4'b1111, 32'h0, 32'h0, 4'h0};
        run_vec(v);

        // Non-splitting instance rejects a word-crossing store
        @(negedge clk);
        instruction_data = mk_instr(3'b010);
        data_address     = 32'hFFFF_FFFE;
        store_data       = 32'hCAFE_BABE;
        valid0_i         = 1'b1;
        @(posedge clk);
        #1 valid0_i = 1'b0;
        @(negedge clk);
        check("nosplit_err", {63'b0, err0}, 64'd1);
        check("nosplit_no_req", {63'b0, req0}, 64'd0);
        check("nosplit_ready", {63'b0, ready0}, 64'd1);
        @(negedge clk);
        check("nosplit_err_pulse", {63'b0, err0}, 64'd0);
        check("nosplit_no_req2", {63'b0, req0}, 64'd0);

        // Non-splitting instance still handles an aligned word store
        data_address = 32'h0000_9000;
        store_data   = 32'h5555_AAAA;
        valid0_i     = 1'b1;
        @(posedge clk);
        #1 valid0_i = 1'b0;
        @(negedge clk);
        check("nosplit_req", {63'b0, req0}, 64'd1);
        check("nosplit_addr", {32'b0, addr0}, 64'h0000_9000);
        check("nosplit_wdata", {32'b0, wdata0}, 64'h5555_AAAA);
        @(negedge clk);
        check("nosplit_done", {63'b0, done0}, 64'd1);
        check("nosplit_err_clear", {63'b0, err0}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
